segment_capture: RTL and testbench

SEGMENT_CAPTURE -- requirements
Module: segment_capture

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 21 ++
 rtl/segment_capture.sv | 144 ++++++++++++++
 tb/tb_segment_capture.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph table (active-high, bit 0 = segment a)
// and display geometry constants.
package seg7_pkg;

    localparam int unsigned DIGITS   = 8;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned DIG_IDX_W = 3;
    localparam int unsigned VALUE_W  = DIGITS * NIBBLE_W;

    // Glyphs 0-9, A, b, C, d, E, F encoded as {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg7_encode(input logic [NIBBLE_W-1:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of an active-high segment pattern into a hex nibble.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]    pattern_i,
    output logic                valid_o,
    output logic [NIBBLE_W-1:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b0;
        nibble_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == GLYPH_TABLE[i]) begin
                valid_o  = 1'b1;
                nibble_o = NIBBLE_W'(i);
            end
        end
    end

endmodule

// File: rtl/segment_capture.sv
// Rebuilds the 32-bit value shown on a multiplexed 8-digit 7-segment display by
// sampling each stable anode/cathode pair and assembling a frame of all 8 digits.
module segment_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIGITS-1:0]    anodes,
    input  logic [7:0]           cathodes,
    output logic [VALUE_W-1:0]   numb,
    output logic                 numb_valid,
    output logic                 digit_err,
    output logic [DIG_IDX_W-1:0] err_digit
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0]    an_q;
    logic [7:0]           ca_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cap_done_q, cap_done_d;
    logic [VALUE_W-1:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0]    seen_q, seen_d;
    logic                 frame_err_q, frame_err_d;
    logic [VALUE_W-1:0]   numb_q, numb_d;
    logic                 numb_valid_q, numb_valid_d;
    logic                 digit_err_q, digit_err_d;
    logic [DIG_IDX_W-1:0] err_digit_q, err_digit_d;

    logic                 changed;
    logic                 capture;
    logic [DIGITS-1:0]    sel;
    logic [3:0]           sel_cnt;
    logic [DIG_IDX_W-1:0] sel_idx;
    logic                 glyph_ok;
    logic [NIBBLE_W-1:0]  glyph_nib;
    logic [DIGITS-1:0]    seen_next;
    logic                 frame_err_next;

    seg7_decode u_decode (
        .pattern_i (~ca_q[SEG_W-1:0]),
        .valid_o   (glyph_ok),
        .nibble_o  (glyph_nib)
    );

    // Active-low anodes: exactly one low bit names the driven digit
    always_comb begin
        sel     = ~an_q;
        sel_cnt = '0;
        sel_idx = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sel[i]) begin
                sel_cnt = sel_cnt + 4'd1;
                sel_idx = DIG_IDX_W'(i);
            end
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        cap_done_d     = cap_done_q;
        shadow_d       = shadow_q;
        seen_d         = seen_q;
        frame_err_d    = frame_err_q;
        numb_d         = numb_q;
        numb_valid_d   = 1'b0;
        digit_err_d    = 1'b0;
        err_digit_d    = err_digit_q;
        seen_next      = seen_q;
        frame_err_next = frame_err_q;

        changed = {anodes, cathodes} != {an_q, ca_q};
        // Capture fires once, on the first cycle the counter sits at its ceiling
        capture = (cnt_q == CNT_MAX) && !cap_done_q;

        if (changed) begin
            cnt_d      = '0;
            cap_done_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (capture)          cap_done_d = 1'b1;
        end

        if (capture && (sel_cnt == 4'd1)) begin
            seen_next = seen_q | sel;
            if (glyph_ok) begin
                shadow_d[{sel_idx, 2'b00} +: NIBBLE_W] = glyph_nib;
            end else begin
                frame_err_next = 1'b1;
                digit_err_d    = 1'b1;
                err_digit_d    = sel_idx;
            end

            if (seen_next == {DIGITS{1'b1}}) begin
                if (!frame_err_next) begin
                    numb_d       = shadow_d;
                    numb_valid_d = 1'b1;
                end
                seen_d      = '0;
                frame_err_d = 1'b0;
            end else begin
                seen_d      = seen_next;
                frame_err_d = frame_err_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            an_q         <= '1;
            ca_q         <= '1;
            cnt_q        <= '0;
            cap_done_q   <= 1'b0;
            shadow_q     <= '0;
            seen_q       <= '0;
            frame_err_q  <= 1'b0;
            numb_q       <= '0;
            numb_valid_q <= 1'b0;
            digit_err_q  <= 1'b0;
            err_digit_q  <= '0;
        end else begin
            an_q         <= anodes;
            ca_q         <= cathodes;
            cnt_q        <= cnt_d;
            cap_done_q   <= cap_done_d;
            shadow_q     <= shadow_d;
            seen_q       <= seen_d;
            frame_err_q  <= frame_err_d;
            numb_q       <= numb_d;
            numb_valid_q <= numb_valid_d;
            digit_err_q  <= digit_err_d;
            err_digit_q  <= err_digit_d;
        end
    end

    assign numb       = numb_q;
    assign numb_valid = numb_valid_q;
    assign digit_err  = digit_err_q;
    assign err_digit  = err_digit_q;

endmodule

// File: tb/tb_segment_capture.sv
// Scoreboard bench: a display-scan model drives segment_capture while a forked
// monitor matches every numb_valid / digit_err pulse against queued expectations.
module tb_segment_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  anodes = 8'hFF;
    logic [7:0]  cathodes = 8'hFF;
    logic [31:0] numb;
    logic        numb_valid;
    logic        digit_err;
    logic [2:0]  err_digit;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_numb_q[$];
    logic [2:0]  exp_err_q[$];

    // Independent hand-written glyph table {g..a}, active-high
    logic [6:0] tb_glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    segment_capture #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .numb       (numb),
        .numb_valid (numb_valid),
        .digit_err  (digit_err),
        .err_digit  (err_digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [7:0] ca, input int n);
        anodes   = an;
        cathodes = ca;
        cyc(n);
    endtask

    function automatic logic [7:0] enc(input logic [3:0] nib);
        return {1'b1, ~tb_glyph[nib]};
    endfunction

    // One scan of digits lo..hi; optional bad digit, late glitch, blanking, overlap
    task automatic scan(input logic [31:0] v, input int lo, input int hi, input int dwell,
                        input int bad_d, input int glitch_at, input int blank,
                        input int overlap_after);
        logic [7:0] an;
        logic [7:0] ca;
        for (int d = lo; d <= hi; d++) begin
            an = ~(8'h01 << d);
            ca = enc(v[4*d +: 4]);
            if (d == bad_d) ca = 8'hBF;
            if (glitch_at >= 0) begin
                drive(an, ca, glitch_at);
                drive(an, ca ^ 8'h01, 1);
                drive(an, ca, dwell - glitch_at - 1);
            end else begin
                drive(an, ca, dwell);
            end
            if (blank > 0) drive(8'hFF, 8'hFF, blank);
            if (d == overlap_after) drive(8'hFC, 8'h80, 5);
        end
    endtask

    task automatic drain_check(input string name);
        drive(8'hFF, 8'hFF, 8);
        chk({name, "_numb_q_empty"}, 32'(exp_numb_q.size()), 32'd0);
        chk({name, "_err_q_empty"}, 32'(exp_err_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (numb_valid) begin
                    if (exp_numb_q.size() == 0) begin
                        chk("unexpected_numb_valid", numb, 32'hxxxx_xxxx);
                    end else begin
                        chk("numb_on_valid", numb, exp_numb_q.pop_front());
                    end
                end
                if (digit_err) begin
                    if (exp_err_q.size() == 0) begin
                        chk("unexpected_digit_err", 32'(err_digit), 32'hxxxx_xxxx);
                    end else begin
                        chk("err_digit_on_err", 32'(err_digit), 32'(exp_err_q.pop_front()));
                    end
                end
            end
        join_none

        cyc(3);
        rst = 1'b1;
        chk("reset_numb", numb, 32'h0);
        chk("reset_numb_valid", 32'(numb_valid), 32'h0);
        chk("reset_digit_err", 32'(digit_err), 32'h0);
        chk("reset_err_digit", 32'(err_digit), 32'h0);

        // Clean scans: one numb_valid per full scan
        exp_numb_q.push_back(32'h1234ABCD);
        scan(32'h1234ABCD, 0, 7, 8, -1, -1, 0, -1);
        exp_numb_q.push_back(32'h1234ABCD);
        scan(32'h1234ABCD, 0, 7, 8, -1, -1, 0, -1);
        drain_check("clean");
        chk("clean_numb", numb, 32'h1234ABCD);

        // Invalid glyph on digit 5: error pulse, numb held, no valid
        exp_err_q.push_back(3'd5);
        scan(32'h1234ABCD, 0, 7, 8, 5, -1, 0, -1);
        drain_check("bad_glyph");
        chk("bad_glyph_numb_held", numb, 32'h1234ABCD);
        chk("err_digit_held", 32'(err_digit), 32'd5);
        exp_numb_q.push_back(32'h1234ABCD);
        scan(32'h1234ABCD, 0, 7, 8, -1, -1, 0, -1);
        drain_check("recover");

        // Dwell shorter than the stability window: nothing captured
        do_reset();
        chk("reset2_numb", numb, 32'h0);
        scan(32'h1234ABCD, 0, 7, 3, -1, -1, 0, -1);
        scan(32'h1234ABCD, 0, 7, 3, -1, -1, 0, -1);
        drain_check("short_dwell");
        chk("short_dwell_numb", numb, 32'h0);

        // Late one-cycle cathode glitch inside a 12-clock dwell
        exp_numb_q.push_back(32'hDEADBEEF);
        scan(32'hDEADBEEF, 0, 7, 12, -1, 9, 0, -1);
        drain_check("glitch");
        chk("glitch_numb", numb, 32'hDEADBEEF);

        // Blanking between digits and an overlap burst are ignored
        exp_numb_q.push_back(32'h13579BDF);
        scan(32'h13579BDF, 0, 7, 8, -1, -1, 3, 3);
        drain_check("blank_overlap");
        chk("blank_overlap_numb", numb, 32'h13579BDF);

        // Mid-frame reset discards digits 0..3; frame then needs 4..7 plus 0..3
        scan(32'hCAFEF00D, 0, 3, 8, -1, -1, 0, -1);
        do_reset();
        chk("midreset_numb", numb, 32'h0);
        chk("midreset_err_digit", 32'(err_digit), 32'h0);
        scan(32'hCAFEF00D, 4, 7, 8, -1, -1, 0, -1);
        drive(8'hFF, 8'hFF, 8);
        chk("half_frame_numb", numb, 32'h0);
        exp_numb_q.push_back(32'hCAFEF00D);
        scan(32'hCAFEF00D, 0, 3, 8, -1, -1, 0, -1);
        drain_check("after_reset");
        chk("after_reset_numb", numb, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
